// File: rtl/dual_issue_buffer.sv
// dual_issue_buffer: fetch FIFO plus pairing logic feeding two registered D slots.
// Ports: clk, reset_n; instrF1/instrF2/pcF/fetch_cnt -> fetch_ready;
//        stallD, flushD -> instrD1/2, pcD1/2, validD1/2.
// Optional macro ISSUE_STATS_EN adds dual_cnt/single_cnt/bubble_cnt.
module dual_issue_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instrF1,
    input  logic [31:0] instrF2,
    input  logic [31:0] pcF,
    input  logic [1:0]  fetch_cnt,
    output logic        fetch_ready,
    input  logic        stallD,
    input  logic        flushD,
    output logic [31:0] instrD1,
    output logic [31:0] instrD2,
    output logic [31:0] pcD1,
    output logic [31:0] pcD2,
    output logic        validD1,
    output logic        validD2
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0] dual_cnt,
    output logic [31:0] single_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] head, tail, head1, tail1;
    logic [AW:0]   count;
    logic [1:0]    enq_n, deq_n;
    logic          enq, issue, iss1, iss2;
    logic [31:0]   i1, i2;

    function automatic logic [4:0] dest(input logic [31:0] i);
        logic [4:0] d;
        d = 5'd0;
        case (i[31:26])
            6'b000000: d = (i[5:0] == 6'b001000) ? 5'd0 : i[15:11];
            6'b100011, 6'b001000, 6'b001001, 6'b001100,
            6'b001101, 6'b001010, 6'b001111: d = i[20:16];
            6'b000011: d = 5'd31;
            default:   d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] i);
        return (i[31:26] == 6'b000100) || (i[31:26] == 6'b000101) ||
               (i[31:26] == 6'b000010) || (i[31:26] == 6'b000011) ||
               (i[31:26] == 6'b000000 && i[5:0] == 6'b001000);
    endfunction

    function automatic logic is_mem(input logic [31:0] i);
        return (i[31:26] == 6'b100011) || (i[31:26] == 6'b101011);
    endfunction

    // rs/rt of the younger op are compared even when unused: cheap and safe.
    function automatic logic pair_ok(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d;
        logic       dep;
        d   = dest(a);
        dep = (d != 5'd0) &&
              (b[25:21] == d || b[20:16] == d || dest(b) == d);
        return !(dep || is_ctrl(a) || (is_mem(a) && is_mem(b)));
    endfunction

    assign fetch_ready = ((AW+1)'(DEPTH) - count) >= (AW+1)'(2);
    assign head1 = head + AW'(1);
    assign tail1 = tail + AW'(1);
    assign i1    = instr_mem[head];
    assign i2    = instr_mem[head1];

    // Fetched instructions are dropped on a same-cycle flush.
    assign enq   = fetch_ready && (fetch_cnt != 2'd0) && !flushD;
    assign enq_n = !enq ? 2'd0 : (fetch_cnt == 2'd2) ? 2'd2 : 2'd1;

    assign issue = !stallD && !flushD;
    assign iss1  = issue && (count != '0);
    assign iss2  = iss1 && (count >= (AW+1)'(2)) && pair_ok(i1, i2);
    assign deq_n = {1'b0, iss1} + {1'b0, iss2};

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]    <= pcF;
            instr_mem[tail] <= instrF1;
            if (enq_n == 2'd2) begin
                pc_mem[tail1]    <= pcF + 32'd4;
                instr_mem[tail1] <= instrF2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            instrD1 <= '0;
            instrD2 <= '0;
            pcD1    <= '0;
            pcD2    <= '0;
            validD1 <= 1'b0;
            validD2 <= 1'b0;
        end else if (flushD) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            instrD1 <= '0;
            instrD2 <= '0;
            pcD1    <= '0;
            pcD2    <= '0;
            validD1 <= 1'b0;
            validD2 <= 1'b0;
        end else begin
            tail  <= tail + AW'(enq_n);
            head  <= head + AW'(deq_n);
            count <= count + (AW+1)'(enq_n) - (AW+1)'(deq_n);
            if (issue) begin
                instrD1 <= iss1 ? i1 : 32'd0;
                pcD1    <= iss1 ? pc_mem[head] : 32'd0;
                validD1 <= iss1;
                instrD2 <= iss2 ? i2 : 32'd0;
                pcD2    <= iss2 ? pc_mem[head1] : 32'd0;
                validD2 <= iss2;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dual_cnt   <= '0;
            single_cnt <= '0;
            bubble_cnt <= '0;
        end else if (issue) begin
            case (deq_n)
                2'd2:    dual_cnt   <= dual_cnt + 32'd1;
                2'd1:    single_cnt <= single_cnt + 32'd1;
                default: bubble_cnt <= bubble_cnt + 32'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_buffer.sv
// tb_dual_issue_buffer: scoreboard bench for dual_issue_buffer.
// Expected {pc,instr} queued at enqueue, popped as D slots load.
module tb_dual_issue_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instrF1, instrF2, pcF;
    logic [1:0]  fetch_cnt;
    logic        fetch_ready;
    logic        stallD, flushD;
    logic [31:0] instrD1, instrD2, pcD1, pcD2;
    logic        validD1, validD2;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    bit loaded;

    always #5 clk = ~clk;

    dual_issue_buffer #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .instrF1(instrF1), .instrF2(instrF2), .pcF(pcF),
        .fetch_cnt(fetch_cnt), .fetch_ready(fetch_ready),
        .stallD(stallD), .flushD(flushD),
        .instrD1(instrD1), .instrD2(instrD2),
        .pcD1(pcD1), .pcD2(pcD2),
        .validD1(validD1), .validD2(validD2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, rt, rd, funct);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, rs, rt, imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] add_k(input int k);
        return rtype(20, 21, k, 32);
    endfunction

    always @(posedge clk) begin
        loaded = reset_n && !stallD && !flushD;
        #1;
        if (loaded) begin
            if (validD1) begin
                if (sb.size() == 0) check("sb1_size", 64'(sb.size()), 64'd1);
                else check("slot1", {pcD1, instrD1}, sb.pop_front());
            end
            if (validD2) begin
                if (sb.size() == 0) check("sb2_size", 64'(sb.size()), 64'd1);
                else check("slot2", {pcD2, instrD2}, sb.pop_front());
            end
            if (!validD1 && validD2) check("order", 64'(validD2), 64'd0);
        end
    end

    task automatic cyc(input logic [1:0] n, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl);
        fetch_cnt = n;
        pcF       = pc;
        instrF1   = a;
        instrF2   = b;
        stallD    = st;
        flushD    = fl;
        if (fl) sb.delete();
        else if (fetch_ready && n != 2'd0) begin
            sb.push_back({pc, a});
            if (n == 2'd2) sb.push_back({pc + 32'd4, b});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic single_pair(input string tag, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b);
        cyc(2'd2, pc, a, b, 1'b0, 1'b0);
        idle();
        check({tag, "_v1a"}, 64'(validD1), 64'd1);
        check({tag, "_v2a"}, 64'(validD2), 64'd0);
        check({tag, "_pca"}, 64'(pcD1), 64'(pc));
        idle();
        check({tag, "_v1b"}, 64'(validD1), 64'd1);
        check({tag, "_v2b"}, 64'(validD2), 64'd0);
        check({tag, "_pcb"}, 64'(pcD1), 64'(pc + 32'd4));
    endtask

    initial begin
        reset_n = 1'b0;
        fetch_cnt = 2'd0; pcF = '0; instrF1 = '0; instrF2 = '0;
        stallD = 1'b0; flushD = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_v1", 64'(validD1), 64'd0);
        check("rst_v2", 64'(validD2), 64'd0);
        check("rst_pc1", 64'(pcD1), 64'd0);
        check("rst_in2", 64'(instrD2), 64'd0);
        check("rst_rdy", 64'(fetch_ready), 64'd1);
        reset_n = 1'b1;

        cyc(2'd2, 32'h100, rtype(2, 3, 1, 32), rtype(5, 6, 4, 32), 1'b0, 1'b0);
        idle();
        check("ind_v1", 64'(validD1), 64'd1);
        check("ind_v2", 64'(validD2), 64'd1);
        check("ind_pc1", 64'(pcD1), 64'h100);
        check("ind_pc2", 64'(pcD2), 64'h104);

        single_pair("raw", 32'h200, itype(35, 9, 8, 0), rtype(8, 11, 10, 32));
        single_pair("beq", 32'h300, itype(4, 1, 2, 4), itype(8, 4, 3, 1));
        single_pair("mem", 32'h380, itype(35, 2, 1, 0), itype(43, 4, 3, 4));

        cyc(2'd1, 32'h3c0, add_k(9), 32'd0, 1'b0, 1'b0);
        idle();
        check("one_v1", 64'(validD1), 64'd1);
        check("one_v2", 64'(validD2), 64'd0);
        idle();

        cyc(2'd2, 32'h3d0, itype(15, 0, 5, 16'h1234), itype(13, 7, 6, 1),
            1'b0, 1'b0);
        idle();
        check("lui_v2", 64'(validD2), 64'd1);
        idle();
        check("bub_v1", 64'(validD1), 64'd0);

        // head/tail now at 3, so seven entries wrap the pointers
        cyc(2'd2, 32'h400, add_k(1), add_k(2), 1'b1, 1'b0);
        cyc(2'd2, 32'h408, add_k(3), add_k(4), 1'b1, 1'b0);
        cyc(2'd2, 32'h410, add_k(5), add_k(6), 1'b1, 1'b0);
        check("rdy_6", 64'(fetch_ready), 64'd1);
        check("stall_v1", 64'(validD1), 64'd0);
        cyc(2'd1, 32'h418, add_k(7), 32'd0, 1'b1, 1'b0);
        check("rdy_7", 64'(fetch_ready), 64'd0);
        cyc(2'd2, 32'h500, add_k(1), add_k(2), 1'b1, 1'b0);
        check("rdy_hold", 64'(fetch_ready), 64'd0);
        idle();
        check("wrap_pc1", 64'(pcD1), 64'h400);
        check("wrap_pc2", 64'(pcD2), 64'h404);
        idle();
        idle();
        idle();
        check("wrap_last", 64'(pcD1), 64'h418);
        check("wrap_v2", 64'(validD2), 64'd0);
        idle();
        check("wrap_empty", 64'(validD1), 64'd0);

        cyc(2'd2, 32'h600, add_k(1), add_k(2), 1'b0, 1'b0);
        cyc(2'd2, 32'h608, add_k(3), add_k(4), 1'b0, 1'b0);
        check("fl_pre", 64'(pcD1), 64'h600);
        cyc(2'd2, 32'h610, add_k(5), add_k(6), 1'b1, 1'b0);
        cyc(2'd1, 32'h618, add_k(7), 32'd0, 1'b1, 1'b0);
        check("fl_rdy5", 64'(fetch_ready), 64'd1);
        cyc(2'd2, 32'h700, add_k(1), add_k(2), 1'b1, 1'b1);
        check("fl_v1", 64'(validD1), 64'd0);
        check("fl_v2", 64'(validD2), 64'd0);
        check("fl_pc1", 64'(pcD1), 64'd0);
        check("fl_in1", 64'(instrD1), 64'd0);
        check("fl_rdy", 64'(fetch_ready), 64'd1);
        idle();
        idle();
        check("fl_drop", 64'(validD1), 64'd0);

        cyc(2'd2, 32'h800, add_k(1), add_k(2), 1'b0, 1'b0);
        cyc(2'd2, 32'h808, add_k(3), add_k(4), 1'b0, 1'b0);
        cyc(2'd1, 32'h810, add_k(5), 32'd0, 1'b1, 1'b0);
        check("mr_pre", 64'(validD1), 64'd1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mr_v1", 64'(validD1), 64'd0);
        check("mr_v2", 64'(validD2), 64'd0);
        check("mr_pc1", 64'(pcD1), 64'd0);
        check("mr_in1", 64'(instrD1), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        idle();
        check("mr_empty", 64'(validD1), 64'd0);
        check("mr_rdy", 64'(fetch_ready), 64'd1);
        cyc(2'd2, 32'h900, add_k(1), add_k(2), 1'b0, 1'b0);
        idle();
        check("mr_post1", 64'(pcD1), 64'h900);
        check("mr_post2", 64'(validD2), 64'd1);
        idle();

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
